lsu: RTL and testbench

Load/store unit that consumes the memory-control fields of the decode control bundle (MEM_we, MEM_op, MemtoReg_SRC) plus the EX address and rs2 data. It performs the access on a req/gnt/rvalid data bus and returns a sign- or zero-extended writeback result. It sits between EX and WB and stalls the pipeline while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu.sv | 202 ++++++++++++++++++++
 tb/tb_lsu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   - mem_op encodings (byte/half/word/ubyte/uhalf); any other code is a word access
//   - 2-bit FSM state encoding exposed as lsu_state_e
//   - data bus / byte-enable widths and types
//   - helpers for access size, signedness and alignment
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic [DATA_W-1:0] data_bus_t;
  typedef logic [BE_W-1:0]   byte_en_t;

  localparam logic [2:0] MEM_OP_BYTE  = 3'b000;
  localparam logic [2:0] MEM_OP_HALF  = 3'b001;
  localparam logic [2:0] MEM_OP_WORD  = 3'b010;
  localparam logic [2:0] MEM_OP_UBYTE = 3'b100;
  localparam logic [2:0] MEM_OP_UHALF = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Unknown encodings fall through to a word access.
  function automatic acc_size_e op_size(input logic [2:0] op);
    case (op)
      MEM_OP_BYTE, MEM_OP_UBYTE: return SZ_BYTE;
      MEM_OP_HALF, MEM_OP_UHALF: return SZ_HALF;
      default:                   return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [2:0] op);
    return (op == MEM_OP_UBYTE) || (op == MEM_OP_UHALF);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
    case (op_size(op))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   mem_op    in   access encoding (see lsu_pkg)
//   offset    in   byte offset within the word (addr[1:0])
//   wdata     in   raw store data (rs2)
//   rdata     in   raw bus read data
//   be        out  byte enables for the access (loads and stores)
//   wdata_rep out  store data replicated across all lanes of the access size
//   rdata_ext out  selected load lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0] mem_op,
  input  logic [1:0] offset,
  input  data_bus_t  wdata,
  input  data_bus_t  rdata,
  output byte_en_t   be,
  output data_bus_t  wdata_rep,
  output data_bus_t  rdata_ext
);

  data_bus_t   rshift;
  logic [15:0] half_lane;
  logic        uns;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    rshift    = rdata >> {offset, 3'b000};
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    uns       = op_unsigned(mem_op);
    case (op_size(mem_op))
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      end
      SZ_HALF: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between EX and WB.
// Optional feature macro: LSU_TIMEOUT_EN (adds TIMEOUT_CYCLES parameter and bus-error timeout).
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-low reset
//   i_valid               EX presents a load/store (sampled only in IDLE)
//   i_mem_we, i_mem_op    store flag and access encoding
//   i_addr, i_wdata       effective address and store data
//   i_regd_addr           destination register
//   o_stall               hold upstream pipeline
//   o_bus_*               request side of the data bus
//   i_bus_gnt/rvalid/rdata bus grant and response
//   o_wb_*                one-cycle writeback result
//   o_misaligned, o_bus_err one-cycle error pulses, aligned with o_wb_valid
//
// Handshake: EX asserts i_valid; the op is accepted in the IDLE cycle where
// i_valid=1, and o_stall holds EX from that cycle until DONE. o_stall is low
// in DONE, so EX advances on the same edge that ends o_wb_valid. The bus
// request (o_bus_req plus addr/we/be/wdata) is held stable until a cycle with
// i_bus_gnt=1; exactly one i_bus_rvalid is then expected, possibly in the
// grant cycle itself. rvalid without a preceding grant is ignored.
module lsu
  import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_mem_we,
  input  logic [2:0]  i_mem_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_regd_addr,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  lsu_state_e state_q, state_d;

  logic       we_q, mis_q;
  logic [2:0] op_q;
  data_bus_t  addr_q, wdata_q, rdata_q;
  logic [4:0] rd_q;

  logic       latch, capture, misaligned_in, timeout_hit, err_flag;
  byte_en_t   be;
  data_bus_t  wdata_rep, rdata_ext;

  assign misaligned_in = is_misaligned(i_mem_op, i_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // cnt_q counts completed REQ/WAIT cycles; the TIMEOUT_CYCLES-th one ends the wait.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_flag    = err_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (latch) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        // Leaving REQ/WAIT for DONE without a response can only be a timeout.
        if (state_d == ST_DONE && !capture) err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_flag    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          latch   = 1'b1;
          state_d = misaligned_in ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_bus_gnt && i_bus_rvalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end else if (i_bus_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_bus_rvalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        we_q    <= i_mem_we;
        mis_q   <= misaligned_in;
        op_q    <= i_mem_op;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        rd_q    <= i_regd_addr;
        rdata_q <= '0;
      end
      if (capture) rdata_q <= i_bus_rdata;
    end
  end

  lsu_align u_align (
    .mem_op    (op_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    o_stall      = 1'b0;
    o_bus_req    = 1'b0;
    o_bus_we     = 1'b0;
    o_bus_addr   = '0;
    o_bus_be     = '0;
    o_bus_wdata  = '0;
    o_wb_valid   = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_addr    = '0;
    o_wb_data    = '0;
    o_misaligned = 1'b0;
    o_bus_err    = 1'b0;
    case (state_q)
      ST_IDLE: o_stall = i_valid;
      ST_REQ: begin
        o_stall     = 1'b1;
        o_bus_req   = 1'b1;
        o_bus_we    = we_q;
        o_bus_addr  = {addr_q[31:2], 2'b00};
        o_bus_be    = be;
        o_bus_wdata = we_q ? wdata_rep : '0;
      end
      ST_WAIT: o_stall = 1'b1;
      ST_DONE: begin
        o_wb_valid   = 1'b1;
        o_wb_we      = !we_q && !mis_q && !err_flag;
        o_wb_addr    = rd_q;
        o_wb_data    = (!we_q && !mis_q && !err_flag) ? rdata_ext : '0;
        o_misaligned = mis_q;
        o_bus_err    = err_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a behavioural byte-lane model and a
// per-cycle compare process fed by an expected-result queue.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk, i_reset, i_valid, i_mem_we;
  logic [2:0]  i_mem_op;
  logic [31:0] i_addr, i_wdata, i_bus_rdata;
  logic [4:0]  i_regd_addr;
  logic        i_bus_gnt, i_bus_rvalid;
  logic        o_stall, o_bus_req, o_bus_we, o_wb_valid, o_wb_we, o_misaligned, o_bus_err;
  logic [31:0] o_bus_addr, o_bus_wdata, o_wb_data;
  logic [3:0]  o_bus_be;
  logic [4:0]  o_wb_addr;

  lsu dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_we(i_mem_we),
    .i_mem_op(i_mem_op), .i_addr(i_addr), .i_wdata(i_wdata), .i_regd_addr(i_regd_addr),
    .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        mis;
    logic        err;
    int          issue_cyc;
    int          done_cyc;
    bit          lit_en;
    logic [31:0] lit_data;
    int          lit_lat;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  logic        exp_req, exp_bwe;
  logic [31:0] exp_baddr, exp_bwdata;
  logic [3:0]  exp_be;
  bit          lit_bus_en;
  logic [3:0]  lit_be;
  logic [31:0] lit_wd;

  int errors = 0;
  int checks = 0;
  localparam int NEVER = 32'h7fff_ffff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int acc_bytes(input logic [2:0] op);
    if (op == MEM_OP_BYTE || op == MEM_OP_UBYTE) return 1;
    if (op == MEM_OP_HALF || op == MEM_OP_UHALF) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] op, input logic [31:0] addr);
    return (addr % acc_bytes(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
    int n = acc_bytes(op);
    logic [3:0] mask = 4'((1 << n) - 1);
    return mask << addr[1:0];
  endfunction

  function automatic logic [31:0] m_wrep(input logic [2:0] op, input logic [31:0] w);
    logic [31:0] r = '0;
    int n = acc_bytes(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int n = acc_bytes(op);
    logic [31:0] mask = (n == 4) ? 32'hffff_ffff : ((32'd1 << (8*n)) - 1);
    logic [31:0] v = (rdata >> (8 * int'(addr[1:0]))) & mask;
    if ((op == MEM_OP_BYTE || op == MEM_OP_HALF) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic    exp_stall, exp_v;
    wb_exp_t e;
    exp_v = (exp_q.size() != 0) && (cyc == exp_q[0].done_cyc);
    if (exp_v)                  exp_stall = 1'b0;
    else if (exp_q.size() != 0) exp_stall = 1'b1;
    else                        exp_stall = i_valid;
    check("stall", 32'(o_stall), 32'(exp_stall));
    check("bus_req", 32'(o_bus_req), 32'(exp_req));
    if (exp_req) begin
      check("bus_addr", o_bus_addr, exp_baddr);
      check("bus_be", 32'(o_bus_be), 32'(exp_be));
      check("bus_we", 32'(o_bus_we), 32'(exp_bwe));
      if (exp_bwe) check("bus_wdata", o_bus_wdata, exp_bwdata);
      if (lit_bus_en) begin
        check("lit_bus_be", 32'(o_bus_be), 32'(lit_be));
        check("lit_bus_wdata", o_bus_wdata, lit_wd);
      end
    end
    check("wb_valid", 32'(o_wb_valid), 32'(exp_v));
    if (exp_v) begin
      e = exp_q.pop_front();
      check("wb_we", 32'(o_wb_we), 32'(e.we));
      check("wb_addr", 32'(o_wb_addr), 32'(e.rd));
      check("wb_data", o_wb_data, e.data);
      check("misaligned", 32'(o_misaligned), 32'(e.mis));
      check("bus_err", 32'(o_bus_err), 32'(e.err));
      if (e.lit_en) begin
        check("lit_wb_data", o_wb_data, e.lit_data);
        check("lit_latency", 32'(cyc - e.issue_cyc), 32'(e.lit_lat));
      end
    end else begin
      check("idle_wb_we", 32'(o_wb_we), 32'd0);
      check("idle_misaligned", 32'(o_misaligned), 32'd0);
      check("idle_bus_err", 32'(o_bus_err), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
  endtask

  // g: cycles the grant is withheld; rv: cycles from grant to rvalid (-1: never)
  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input int g, input int rv,
                         input bit lit_en, input logic [31:0] lit_data, input int lit_lat,
                         input bit lb_en, input logic [3:0] lbe, input logic [31:0] lwd);
    wb_exp_t e;
    bit mis;
    @(posedge clk); #1;
    i_valid = 1'b1; i_mem_we = we; i_mem_op = op; i_addr = addr; i_wdata = wdata;
    i_regd_addr = rd;
    mis         = m_mis(op, addr);
    e.rd        = rd;
    e.mis       = mis;
    e.err       = 1'b0;
    e.we        = !we && !mis;
    e.data      = e.we ? m_load(op, addr, rdata) : 32'd0;
    e.issue_cyc = cyc + 1;
    e.lit_en    = lit_en;
    e.lit_data  = lit_data;
    e.lit_lat   = lit_lat;
    if (mis)         e.done_cyc = e.issue_cyc;
    else if (rv >= 0) e.done_cyc = e.issue_cyc + 1 + g + rv;
    else begin
`ifdef LSU_TIMEOUT_EN
      e.done_cyc = e.issue_cyc + 16;
      e.err      = 1'b1;
      e.we       = 1'b0;
      e.data     = 32'd0;
`else
      e.done_cyc = NEVER;
`endif
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble EX-side inputs: the unit must work from its latched copy.
    i_valid = 1'b0; i_mem_we = 1'($urandom_range(0, 1)); i_mem_op = 3'($urandom_range(0, 7));
    i_addr = $urandom; i_wdata = $urandom; i_regd_addr = 5'($urandom_range(0, 31));
    if (!mis) begin
      exp_req = 1'b1; exp_bwe = we; exp_baddr = {addr[31:2], 2'b00};
      exp_be = m_be(op, addr); exp_bwdata = m_wrep(op, wdata);
      lit_bus_en = lb_en; lit_be = lbe; lit_wd = lwd;
      for (int i = 0; i < g; i++) begin
        i_bus_rvalid = 1'b1; i_bus_rdata = $urandom;  // stray response without grant
        @(posedge clk); #1;
      end
      i_bus_gnt = 1'b1;
      i_bus_rvalid = (rv == 0);
      i_bus_rdata = (rv == 0) ? rdata : $urandom;
      @(posedge clk); #1;
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; exp_req = 1'b0; lit_bus_en = 1'b0;
      if (rv > 0) begin
        repeat (rv - 1) begin @(posedge clk); #1; end
        i_bus_rvalid = 1'b1; i_bus_rdata = rdata;
        @(posedge clk); #1;
        i_bus_rvalid = 1'b0;
      end
    end
    if (rv >= 0 || mis) wait_done(20);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, 32'(o_stall), 32'd0);
    check({tag, "_bus_req"}, 32'(o_bus_req), 32'd0);
    check({tag, "_bus_addr"}, o_bus_addr, 32'd0);
    check({tag, "_bus_be"}, 32'(o_bus_be), 32'd0);
    check({tag, "_bus_wdata"}, o_bus_wdata, 32'd0);
    check({tag, "_wb_valid"}, 32'(o_wb_valid), 32'd0);
    check({tag, "_wb_data"}, o_wb_data, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_mem_we = 1'b0; i_mem_op = '0; i_addr = '0;
    i_wdata = '0; i_regd_addr = '0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
    exp_req = 1'b0; exp_bwe = 1'b0; exp_baddr = '0; exp_be = '0; exp_bwdata = '0;
    lit_bus_en = 1'b0; lit_be = '0; lit_wd = '0;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    i_reset = 1'b1;

    // lb 0x103: sign-extended top lane, fastest path
    run_txn(1'b0, MEM_OP_BYTE, 32'h103, 32'h0, 32'h80ff_1234, 5'd3, 0, 0,
            1'b1, 32'hffff_ff80, 1, 1'b1, 4'b1000, 32'h0);
    // lhu / lh at 0x102
    run_txn(1'b0, MEM_OP_UHALF, 32'h102, 32'h0, 32'h8001_0000, 5'd4, 0, 1,
            1'b1, 32'h0000_8001, 2, 1'b0, 4'b0, 32'h0);
    run_txn(1'b0, MEM_OP_HALF, 32'h102, 32'h0, 32'h8001_0000, 5'd5, 1, 0,
            1'b1, 32'hffff_8001, 2, 1'b0, 4'b0, 32'h0);
    // sh 0x202 with grant withheld 3 cycles
    run_txn(1'b1, MEM_OP_HALF, 32'h202, 32'h1234_abcd, 32'h0, 5'd6, 3, 1,
            1'b1, 32'h0, 5, 1'b1, 4'b1100, 32'habcd_abcd);
    // lw 0x101 misaligned
    run_txn(1'b0, MEM_OP_WORD, 32'h101, 32'h0, 32'h0, 5'd7, 0, 0,
            1'b1, 32'h0, 0, 1'b0, 4'b0, 32'h0);
    // further patterns
    run_txn(1'b1, MEM_OP_BYTE, 32'h001, 32'hdead_be55, 32'h0, 5'd8, 0, 2,
            1'b0, 32'h0, 0, 1'b1, 4'b0010, 32'h5555_5555);
    run_txn(1'b0, MEM_OP_UBYTE, 32'h002, 32'h0, 32'h00f0_0000, 5'd9, 2, 0,
            1'b1, 32'h0000_00f0, 3, 1'b0, 4'b0, 32'h0);
    run_txn(1'b0, MEM_OP_BYTE, 32'h040, 32'h0, 32'h1234_567f, 5'd10, 0, 0,
            1'b1, 32'h0000_007f, 1, 1'b0, 4'b0, 32'h0);
    run_txn(1'b0, MEM_OP_WORD, 32'h010, 32'h0, 32'hcafe_f00d, 5'd11, 1, 1,
            1'b1, 32'hcafe_f00d, 3, 1'b1, 4'b1111, 32'h0);
    run_txn(1'b1, MEM_OP_WORD, 32'h014, 32'h0bad_c0de, 32'h0, 5'd12, 0, 0,
            1'b0, 32'h0, 0, 1'b1, 4'b1111, 32'h0bad_c0de);
    run_txn(1'b0, 3'b111, 32'h020, 32'h0, 32'h8765_4321, 5'd13, 0, 0,
            1'b1, 32'h8765_4321, 1, 1'b0, 4'b0, 32'h0);
    run_txn(1'b0, 3'b111, 32'h022, 32'h0, 32'h0, 5'd14, 0, 0,
            1'b0, 32'h0, 0, 1'b0, 4'b0, 32'h0);
    run_txn(1'b1, MEM_OP_HALF, 32'h105, 32'h0, 32'h0, 5'd15, 0, 0,
            1'b0, 32'h0, 0, 1'b0, 4'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      op = (i % 2 == 0) ? MEM_OP_HALF : MEM_OP_UBYTE;
      a  = 32'h300 + 32'(i);
      run_txn(1'(i % 3 == 0), op, a, $urandom, $urandom, 5'(16 + i),
              $urandom_range(0, 2), $urandom_range(0, 2),
              1'b0, 32'h0, 0, 1'b0, 4'b0, 32'h0);
    end

    // lw granted but never answered
    run_txn(1'b0, MEM_OP_WORD, 32'h400, 32'h0, 32'h0, 5'd1, 0, -1,
            1'b0, 32'h0, 0, 1'b0, 4'b0, 32'h0);
`ifdef LSU_TIMEOUT_EN
    wait_done(30);
`else
    repeat (20) begin @(posedge clk); #1; end
    check("stuck_stall", 32'(o_stall), 32'd1);
    i_reset = 1'b0; exp_q.delete();
    #1 check_outputs_zero("stuck_reset");
    @(posedge clk); #1;
    i_reset = 1'b1;
`endif

    // reset while in WAIT, late rvalid afterwards must be ignored
    run_txn(1'b0, MEM_OP_WORD, 32'h500, 32'h0, 32'h0, 5'd2, 0, -1,
            1'b0, 32'h0, 0, 1'b0, 4'b0, 32'h0);
    @(posedge clk); #1;
    i_reset = 1'b0; exp_q.delete();
    #1 check_outputs_zero("wait_reset");
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    i_bus_rvalid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("late_rvalid_wb_valid", 32'(o_wb_valid), 32'd0);
    check("late_rvalid_stall", 32'(o_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
